// File: rtl/uart_tx_fifo.sv
// 8N1 UART transmitter with a small byte FIFO in front of the shifter.
// The line is registered; busy and in_ready derive only from registered state.
module uart_tx_fifo #(
  parameter int CLK_DIV    = 16,
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = $clog2(FIFO_DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [7:0]       in_data,
  output logic             in_ready,
  output logic             uart_tx,
  output logic             busy,
  output logic [CNT_W-1:0] fifo_count
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int DW = $clog2(CLK_DIV);
  localparam logic [DW-1:0]    DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

  // state | meaning
  // IDLE  | line high, waiting for a queued byte
  // START | start bit (line low)
  // DATA  | eight data bits, LSB first
  // STOP  | stop bit (line high); may chain straight into the next START
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t        state;
  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [DW-1:0] div_cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shift;
  logic [7:0]    head;
  logic          push;
  logic          pop;
  logic          fifo_empty;
  logic          bit_end;

  assign fifo_empty = (fifo_count == '0);
  assign in_ready   = (fifo_count < FULL_CNT);
  assign push       = in_valid && in_ready;
  assign bit_end    = (div_cnt == DIV_LAST);
  assign head       = mem[rd_ptr];
  assign pop        = !fifo_empty && ((state == IDLE) || ((state == STOP) && bit_end));
  assign busy       = (state != IDLE) || !fifo_empty;

  always_ff @(posedge clk) begin
    if (!rst && push) begin
      mem[wr_ptr] <= in_data;
    end
  end

  // Pointers are sized to the depth, so wrap-around is free.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      div_cnt <= '0;
      bit_idx <= '0;
      shift   <= '0;
      uart_tx <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          uart_tx <= 1'b1;
          if (!fifo_empty) begin
            shift   <= head;
            div_cnt <= '0;
            uart_tx <= 1'b0;
            state   <= START;
          end
        end
        START: begin
          if (bit_end) begin
            div_cnt <= '0;
            bit_idx <= '0;
            uart_tx <= shift[0];
            state   <= DATA;
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end
        DATA: begin
          if (bit_end) begin
            div_cnt <= '0;
            shift   <= {1'b0, shift[7:1]};
            if (bit_idx == 3'd7) begin
              uart_tx <= 1'b1;
              state   <= STOP;
            end else begin
              bit_idx <= bit_idx + 3'd1;
              uart_tx <= shift[1];
            end
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end
        STOP: begin
          if (bit_end) begin
            div_cnt <= '0;
            // Chain the next queued byte with no idle gap between frames.
            if (!fifo_empty) begin
              shift   <= head;
              uart_tx <= 1'b0;
              state   <= START;
            end else begin
              state <= IDLE;
            end
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end
        default: begin
          state   <= IDLE;
          uart_tx <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: two instances (CLK_DIV 4 and 2) against a cycle-level
// frame model, plus a line decoder feeding a byte scoreboard.
module tb_uart_tx_fifo;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid   [2];
  logic [7:0] in_data    [2];
  logic       in_ready   [2];
  logic       uart_tx    [2];
  logic       busy       [2];
  logic [2:0] fifo_count [2];

  int errors = 0;
  int checks = 0;

  // model state: queued bytes, cycles left in current frame, byte on the line
  logic [7:0] mq   [2][$];
  logic [7:0] sbq  [2][$];
  int         rem  [2];
  logic [7:0] cur  [2];
  bit         acc  [2];
  bit         mdl_ok [2];
  // decoder state
  bit         dact  [2];
  int         dc    [2];
  logic [7:0] dbyte [2];

  logic [7:0] burst [6];

  always #5 clk = ~clk;

  uart_tx_fifo #(.CLK_DIV(4), .FIFO_DEPTH(4)) u_dut4 (
    .clk(clk), .rst(rst), .in_valid(in_valid[0]), .in_data(in_data[0]),
    .in_ready(in_ready[0]), .uart_tx(uart_tx[0]), .busy(busy[0]), .fifo_count(fifo_count[0])
  );

  uart_tx_fifo #(.CLK_DIV(2), .FIFO_DEPTH(4)) u_dut2 (
    .clk(clk), .rst(rst), .in_valid(in_valid[1]), .in_data(in_data[1]),
    .in_ready(in_ready[1]), .uart_tx(uart_tx[1]), .busy(busy[1]), .fifo_count(fifo_count[1])
  );

  function automatic void chk(string name, int k, int act, int req);
    checks = checks + 1;
    if (act !== req) begin
      errors = errors + 1;
      $display("FAIL %s dut%0d t=%0t got=%0h expected=%0h", name, k, $time, act, req);
    end
  endfunction

  // Model advances once per negedge for the rising edge that just happened;
  // inputs are only changed a little after the negedge, so they still hold
  // the values that edge sampled.
  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      int dv;
      int p;
      int b;
      int bi;
      bit exp_tx;
      dv = (k == 0) ? 4 : 2;
      if (rst) begin
        mq[k].delete();
        sbq[k].delete();
        rem[k]    = 0;
        acc[k]    = 1'b0;
        dact[k]   = 1'b0;
        dc[k]     = 0;
        mdl_ok[k] = 1'b1;
      end else if (mdl_ok[k]) begin
        acc[k] = in_valid[k] && (mq[k].size() < 4);
        if (rem[k] > 1) begin
          rem[k] = rem[k] - 1;
        end else if (mq[k].size() > 0) begin
          cur[k] = mq[k].pop_front();
          rem[k] = 10 * dv;
        end else begin
          rem[k] = 0;
        end
        if (acc[k]) begin
          mq[k].push_back(in_data[k]);
          sbq[k].push_back(in_data[k]);
        end
      end

      if (mdl_ok[k]) begin
        if (rem[k] == 0) begin
          exp_tx = 1'b1;
        end else begin
          p = 10 * dv - rem[k];
          b = p / dv;
          if (b == 0)      exp_tx = 1'b0;
          else if (b == 9) exp_tx = 1'b1;
          else             exp_tx = cur[k][3'(b - 1)];
        end
        chk("uart_tx", k, int'(uart_tx[k]), int'(exp_tx));
        chk("in_ready", k, int'(in_ready[k]), int'(mq[k].size() < 4));
        chk("busy", k, int'(busy[k]), int'((rem[k] > 0) || (mq[k].size() > 0)));
        chk("fifo_count", k, int'(fifo_count[k]), mq[k].size());

        if (!rst) begin
          if (dact[k]) begin
            dc[k] = dc[k] + 1;
          end else if (uart_tx[k] == 1'b0) begin
            dact[k] = 1'b1;
            dc[k]   = 0;
          end
          if (dact[k] && ((dc[k] % dv) == dv / 2)) begin
            bi = dc[k] / dv;
            if (bi == 0) begin
              chk("start_bit", k, int'(uart_tx[k]), 0);
            end else if (bi <= 8) begin
              dbyte[k][3'(bi - 1)] = uart_tx[k];
            end else begin
              chk("stop_bit", k, int'(uart_tx[k]), 1);
              chk("sb_nonempty", k, int'(sbq[k].size() > 0), 1);
              if (sbq[k].size() > 0) begin
                chk("rx_byte", k, int'(dbyte[k]), int'(sbq[k].pop_front()));
              end
              dact[k] = 1'b0;
            end
          end
        end
      end
    end
  end

  task automatic step();
    @(negedge clk);
    #2;
  endtask

  task automatic wait_cycles(int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    int idx;
    int guard;
    rst = 1'b1;
    for (int k = 0; k < 2; k++) begin
      in_valid[k] = 1'b0;
      in_data[k]  = 8'h00;
      rem[k]      = 0;
      mdl_ok[k]   = 1'b0;
      dact[k]     = 1'b0;
    end
    burst = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
    wait_cycles(2);
    rst = 1'b0;
    wait_cycles(2);

    // single frames: 0xA5 at CLK_DIV=4, 0x81 at CLK_DIV=2
    in_valid[0] = 1'b1; in_data[0] = 8'hA5;
    in_valid[1] = 1'b1; in_data[1] = 8'h81;
    step();
    in_valid[0] = 1'b0; in_valid[1] = 1'b0;
    wait_cycles(50);

    // back-to-back 0x00, 0xFF
    in_valid[0] = 1'b1; in_data[0] = 8'h00;
    step();
    in_data[0] = 8'hFF;
    step();
    in_valid[0] = 1'b0;
    wait_cycles(90);

    // hold valid with six bytes; scramble data whenever the FIFO is full
    idx = 0;
    guard = 0;
    while (idx < 6 && guard < 400) begin
      in_valid[0] = 1'b1;
      in_data[0]  = (mq[0].size() >= 4) ? 8'($urandom) : burst[idx];
      step();
      if (acc[0]) idx++;
      guard++;
    end
    in_valid[0] = 1'b0;
    wait_cycles(6 * 40 + 20);

    // reset during data bit 3 of 0x5A with two bytes queued behind it
    in_valid[0] = 1'b1; in_data[0] = 8'h5A; step();
    in_data[0] = 8'h11; step();
    in_data[0] = 8'h22; step();
    in_valid[0] = 1'b0;
    guard = 0;
    while (rem[0] != 23 && guard < 100) begin
      step();
      guard++;
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    wait_cycles(3);
    in_valid[0] = 1'b1; in_data[0] = 8'h3C; step();
    in_valid[0] = 1'b0;
    wait_cycles(50);

    // random traffic on both instances, with one reset in the middle
    for (int c = 0; c < 3000; c++) begin
      for (int k = 0; k < 2; k++) begin
        in_valid[k] = ($urandom_range(0, 3) != 0);
        in_data[k]  = 8'($urandom);
      end
      rst = (c == 1500);
      step();
    end
    rst = 1'b0;
    in_valid[0] = 1'b0; in_valid[1] = 1'b0;
    wait_cycles(5 * 40 + 20);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
- UART transmitter for the board-level `uart_tx` pin: 8N1 framing, fixed integer clock divider.
- Fronted by a small FIFO so a CPU-side MMIO/console path can push bytes with a valid/ready handshake.
- Instantiated beside the top-level I/O and drives `uart_tx` directly (registered).
- Complements the board's UART receive side.

Parameters:
- CLK_DIV, 16, clk cycles per UART bit; legal range >= 2.
- FIFO_DEPTH, 4, FIFO entries; power of 2, >= 2.
- CNT_W, $clog2(FIFO_DEPTH)+1, width of `fifo_count`.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  producer offers `in_data` this cycle.
- in_data  input  8  byte to transmit.
- in_ready  output  1  FIFO can accept; transfer occurs when `in_valid && in_ready` at a rising edge.
- uart_tx  output  1  serial line, idle high, registered.
- busy  output  1  high while a frame is in flight or the FIFO is non-empty.
- fifo_count  output  CNT_W  number of bytes queued in the FIFO, excluding the byte in the shifter.

Behaviour:
- Reset (`rst` sampled high at a rising edge):
  - Outputs: `uart_tx`=1, `in_ready`=1, `busy`=0, `fifo_count`=0.
  - Internal: state=IDLE; FIFO pointers, bit counter and divider counter all 0.
- Reset mid-frame aborts the frame at once: line high from the next edge, FIFO contents discarded, no partial frame resumes.
- FIFO:
  - `in_ready` = (`fifo_count` < FIFO_DEPTH), computed from registered state only.
  - A pop in the same cycle does NOT admit a push when full.
  - Push and pop in the same cycle leave the count unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
- Divider counter: counts 0..CLK_DIV-1; reaching CLK_DIV-1 ends the current bit period.
- State machine, states IDLE, START, DATA, STOP:
  - IDLE: `uart_tx`=1. If FIFO non-empty: pop head into the 8-bit shift register, clear the divider, go to START. `uart_tx` registers 0 at that same edge.
  - START: line 0 for CLK_DIV cycles, then DATA with bit index 0.
  - DATA: line = shift[0] (LSB first). Each bit lasts CLK_DIV cycles. At bit end, shift right and increment the index. After index 7 ends, go to STOP.
  - STOP: line 1 for CLK_DIV cycles. At the end:
    - FIFO non-empty: pop and go directly to START (back-to-back, no idle gap).
    - FIFO empty: go to IDLE.
- Timing:
  - Frame length = 10*CLK_DIV cycles.
  - Latency from acceptance edge (empty FIFO, IDLE) to `uart_tx` falling = 1 cycle. The byte is accepted at edge N, popped at edge N+1, and `uart_tx`=0 after edge N+1.
- `busy` = (state != IDLE) || (`fifo_count` != 0). Registered or derived from registered state, with no combinational path from inputs.
- `in_data` is sampled only on a handshake. Changes to `in_data` while `in_ready`=0 have no effect.

Test Plan:
- CLK_DIV=4, after reset push 0xA5 at edge N:
  - `uart_tx` low from N+1 for 4 cycles.
  - Then bits 1,0,1,0,0,1,0,1, each 4 cycles.
  - Stop high for 4 cycles; total frame 40 cycles.
  - `busy` falls right after the stop bit; `fifo_count` returns to 0.
- CLK_DIV=4, push 0x00 then 0xFF on consecutive cycles:
  - Two frames, contiguous over 80 cycles.
  - Stop bit of frame 1 is followed immediately by the start bit of frame 2.
- CLK_DIV=4, FIFO_DEPTH=4, hold `in_valid`=1 with 6 distinct bytes from IDLE:
  - Exactly 5 bytes are accepted (1 popped to the shifter, 4 queued).
  - `in_ready`=0 with `fifo_count`=4.
  - `in_ready` returns to 1 one cycle after the second pop (end of frame 1).
  - All bytes transmit in order.
- While `in_ready`=0, toggle `in_data` with `in_valid`=1: no extra acceptance, transmitted bytes unchanged.
- Assert `rst` for one cycle during data bit 3 of 0x5A with 2 bytes queued:
  - `uart_tx`=1, `fifo_count`=0, `busy`=0 after that edge.
  - A subsequent push of 0x3C transmits a clean, correct frame.
- CLK_DIV=2 (minimum): push 0x81 → each bit exactly 2 cycles, frame exactly 20 cycles.
